serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Multi-cycle ripple-borrow subtractor; the inverse operation of our combinational 16-bit ripple adders.
//  Computes diff = a - b - bin, DIGIT bits per cycle, LSB first, trading area for latency.
//  Sits behind the lgsynth91 arithmetic benches as the sequential counterpart checker/datapath.
//  Uses a valid/ready handshake on both the operand side and the result side.
// PARAMETERS
//  WIDTH  16  operand/result width in bits
//  DIGIT  1   bits retired per cycle; must divide WIDTH (elaboration-time error otherwise)
// PORTS
//  clk        in   1      sole clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands present
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow-in
//  out_valid  out  1      result present (high only in DONE)
//  out_ready  in   1      consumer takes result
//  diff       out  WIDTH  (a - b - bin) mod 2^WIDTH
//  bout       out  1      borrow-out: 1 iff a < b + bin (unsigned)
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, all internal regs cleared.
//  Reset mid-operation: the operation aborts immediately; nothing is emitted, and the block restarts in IDLE.
//  FSM: IDLE -(in_valid&in_ready)-> RUN; RUN -(digit count==N-1)-> DONE; DONE -(out_ready)-> IDLE.
//    N = WIDTH/DIGIT.
//  Accept edge: a, b and bin are captured into shift regs and the borrow reg, and the count is set to 0.
//    Input changes after the accept edge are ignored.
//  RUN: each edge subtracts the low DIGIT bits of the a/b shift regs with the borrow reg.
//    Both operand regs shift right by DIGIT.
//    The result digit enters the result reg from the MSB end.
//    The borrow reg takes the digit borrow-out, and the count increments.
//  Latency: out_valid is high after the N-th edge following the accept edge (16 cycles at default).
//  DONE: diff and bout are held stable while out_valid=1 && out_ready=0.
//    On out_ready the block returns to IDLE; out_valid drops and in_ready rises on the next edge.
//  Input and result handshakes never complete in the same cycle; throughput is one operation per N+2 cycles.
//  diff/bout keep their last value outside DONE (not cleared on return to IDLE); only reset clears them.
//  Wrap: a<b wraps modulo 2^WIDTH with bout=1.
//    a==b with bin=1 gives diff=all-ones and bout=1.
//    a==b with bin=0 gives diff=0 and bout=0.
//  in_valid while busy: ignored (in_ready=0); the source must hold its operands until accepted.
//  out_ready while not DONE: no effect.
// STRUCTURE
//  Shared package arith_pkg:
//    sub_state_t enum {IDLE, RUN, DONE}
//    function clog2-based count width CNT_W = $clog2(WIDTH/DIGIT) (min 1).
//  Sub-module serial_sub_digit (combinational, DIGIT bits):
//    inputs  x[DIGIT-1:0], y[DIGIT-1:0], bi
//    outputs d[DIGIT-1:0], bo
//    implemented as a ripple borrow chain, borrow_k+1 = (~x&y) | (~x&borrow_k) | (y&borrow_k).
//  Top level holds the FSM, shift regs, count, and borrow reg.
// TESTING
//  1. Reset, WIDTH=16/DIGIT=1, a=0x1234 b=0x0234 bin=0 -> after 16 edges out_valid=1, diff=0x1000, bout=0.
//  2. a=0x0000 b=0x0001 bin=0 -> diff=0xFFFF bout=1.
//     a=0x8000 b=0x8000 bin=1 -> diff=0xFFFF bout=1.
//  3. Backpressure: hold out_ready=0 for 5 cycles -> diff/bout stable, in_ready=0, and new in_valid is ignored.
//     Release -> IDLE next edge.
//  4. Assert rst_n=0 at RUN cycle 7 -> out_valid=0, diff=0, in_ready=1 immediately.
//     A following a=5 b=3 -> diff=2.
//  5. DIGIT=4: a=0xFFFF b=0xFFFF bin=0 -> out_valid after 4 edges, diff=0, bout=0.
//     Random 1000-op scoreboard vs (a-b-bin) for both DIGIT=1 and DIGIT=4.
//  6. Operands change one cycle after accept (a=0xAAAA->0x5555) -> result reflects the captured 0xAAAA.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the serial subtractor.
//   sub_state_t : controller states (IDLE, RUN, DONE)
//   cnt_width() : width of the digit counter for n digits, never below 1 bit
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_state_t;

   // A single-digit operation still needs a 1-bit counter to exist.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_sub_digit.sv
// One DIGIT-bit slice of a ripple-borrow subtractor (purely combinational).
//   x  : minuend digit
//   y  : subtrahend digit
//   bi : borrow into the least significant bit of the digit
//   d  : difference digit, (x - y - bi) mod 2^DIGIT
//   bo : borrow out of the most significant bit of the digit
module serial_sub_digit #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             bi,
   output logic [DIGIT-1:0] d,
   output logic             bo
);

   // chain[k] is the borrow into bit k; chain[DIGIT] leaves the digit.
   logic [DIGIT:0] chain;

   always_comb begin
      chain    = '0;
      d        = '0;
      chain[0] = bi;
      for (int k = 0; k < DIGIT; k++) begin
         d[k]       = x[k] ^ y[k] ^ chain[k];
         chain[k+1] = (~x[k] & y[k]) | (~x[k] & chain[k]) | (y[k] & chain[k]);
      end
   end

   assign bo = chain[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle ripple-borrow subtractor: diff = a - b - bin, DIGIT bits per
// clock, least significant digit first.
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake; a transfer happens on an edge
//                         where both are high (in_ready is high only in IDLE)
//   a, b, bin           : minuend, subtrahend, borrow-in (captured on accept)
//   out_valid/out_ready : result handshake; a transfer happens on an edge
//                         where both are high (out_valid is high only in DONE)
//   diff, bout          : (a - b - bin) mod 2^WIDTH and the final borrow;
//                         held until the next completed operation or reset
//   state               : current controller state, for observation only
// A source holds valid and its data until ready is seen on a clock edge;
// ready never depends combinationally on valid.
module serial_subtractor
   import arith_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic [1:0]       state
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = cnt_width(N);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_subtractor: DIGIT must divide WIDTH");
   end

   sub_state_t       cur_state;
   sub_state_t       nxt_state;
   logic             accept;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [WIDTH-1:0] res_next;
   logic             borrow;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q;
   logic [DIGIT-1:0] dig_d;
   logic             dig_bo;

   serial_sub_digit #(.DIGIT(DIGIT)) u_digit (
      .x  (a_sh[DIGIT-1:0]),
      .y  (b_sh[DIGIT-1:0]),
      .bi (borrow),
      .d  (dig_d),
      .bo (dig_bo)
   );

   // New digits enter at the top and move down, so after N steps the
   // first (least significant) digit sits at bit 0.
   logic [WIDTH+DIGIT-1:0] res_cat;
   assign res_cat  = {dig_d, res_sh};
   assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state <= IDLE;
      end else begin
         cur_state <= nxt_state;
      end
   end

   always_comb begin
      nxt_state = cur_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      case (cur_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept    = 1'b1;
               nxt_state = RUN;
            end
         end
         RUN: begin
            if (cnt == LAST) begin
               nxt_state = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               nxt_state = IDLE;
            end
         end
         default: begin
            nxt_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         diff_q <= '0;
         bout_q <= 1'b0;
      end else if (accept) begin
         a_sh   <= a;
         b_sh   <= b;
         res_sh <= '0;
         borrow <= bin;
         cnt    <= '0;
      end else if (cur_state == RUN) begin
         a_sh   <= a_sh >> DIGIT;
         b_sh   <= b_sh >> DIGIT;
         res_sh <= res_next;
         borrow <= dig_bo;
         cnt    <= cnt + CNT_W'(1);
         // The published result only changes on the final digit, so diff
         // and bout stay stable across RUN and DONE of the next operation.
         if (cnt == LAST) begin
            diff_q <= res_next;
            bout_q <= dig_bo;
         end
      end
   end

   assign diff  = diff_q;
   assign bout  = bout_q;
   assign state = cur_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor, instances with DIGIT=1 and DIGIT=4.
module tb_serial_subtractor;
   import arith_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        in_valid  [2];
   logic        in_ready  [2];
   logic [15:0] a_in      [2];
   logic [15:0] b_in      [2];
   logic        bin_in    [2];
   logic        out_valid [2];
   logic        out_ready [2];
   logic [15:0] diff_o    [2];
   logic        bout_o    [2];
   logic [1:0]  state_o   [2];

   int total = 0;
   int bad   = 0;
   logic [16:0] exp_q[$];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   serial_subtractor #(.WIDTH(16), .DIGIT(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a(a_in[0]), .b(b_in[0]), .bin(bin_in[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .diff(diff_o[0]), .bout(bout_o[0]), .state(state_o[0])
   );

   serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a(a_in[1]), .b(b_in[1]), .bin(bin_in[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .diff(diff_o[1]), .bout(bout_o[1]), .state(state_o[1])
   );

   // ---------------- checking helper ----------------
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   function automatic int n_of(input int sel);
      return (sel == 0) ? 16 : 4;
   endfunction

   // ---------------- driver ----------------
   // Runs one operation on instance sel; returns the result and the number of
   // edges between the accept edge and out_valid. Operands are scrambled right
   // after the accept edge so a late change would show up in the result.
   task automatic do_op(input int sel, input logic [15:0] av, input logic [15:0] bv,
                        input logic bi, input int hold,
                        output logic [15:0] d, output logic bo, output int lat);
      int guard;
      guard = 0;
      while (!in_ready[sel] && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) chk("in_ready_timeout", 32'd0, 32'd1);
      in_valid[sel] = 1'b1;
      a_in[sel]     = av;
      b_in[sel]     = bv;
      bin_in[sel]   = bi;
      @(negedge clk);
      in_valid[sel] = 1'b0;
      a_in[sel]     = ~av;
      b_in[sel]     = ~bv;
      bin_in[sel]   = ~bi;
      lat = 0;
      while (!out_valid[sel] && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      d  = diff_o[sel];
      bo = bout_o[sel];
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", 32'(out_valid[sel]), 32'd1);
         chk("hold_diff", 32'(diff_o[sel]), 32'(d));
      end
      out_ready[sel] = 1'b1;
      @(negedge clk);
      out_ready[sel] = 1'b0;
      chk("release_valid", 32'(out_valid[sel]), 32'd0);
      chk("release_ready", 32'(in_ready[sel]), 32'd1);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        bin;
      logic [15:0] diff;
      logic        bout;
   } vec_t;

   vec_t vecs[11];

   initial begin
      logic [15:0] d;
      logic        bo;
      int          lat;
      logic [15:0] held_d;
      logic        held_bo;

      vecs[0]  = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0};
      vecs[1]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
      vecs[2]  = '{16'h8000, 16'h8000, 1'b1, 16'hFFFF, 1'b1};
      vecs[3]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0};
      vecs[4]  = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
      vecs[5]  = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0};
      vecs[6]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1};
      vecs[7]  = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0};
      vecs[8]  = '{16'h0000, 16'hFFFF, 1'b0, 16'h0001, 1'b1};
      vecs[9]  = '{16'h7FFF, 16'h8000, 1'b0, 16'hFFFF, 1'b1};
      vecs[10] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1};

      for (int s = 0; s < 2; s++) begin
         in_valid[s]  = 1'b0;
         out_ready[s] = 1'b0;
         a_in[s]      = '0;
         b_in[s]      = '0;
         bin_in[s]    = 1'b0;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // reset state
      for (int s = 0; s < 2; s++) begin
         chk("rst_in_ready", 32'(in_ready[s]), 32'd1);
         chk("rst_out_valid", 32'(out_valid[s]), 32'd0);
         chk("rst_diff", 32'(diff_o[s]), 32'd0);
         chk("rst_bout", 32'(bout_o[s]), 32'd0);
         chk("rst_state", 32'(state_o[s]), 32'(IDLE));
      end

      // table vectors on both digit sizes, latency checked
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 11; i++) begin
            do_op(s, vecs[i].a, vecs[i].b, vecs[i].bin, 0, d, bo, lat);
            chk("vec_latency", 32'(lat), 32'(n_of(s)));
            chk("vec_diff", 32'(d), 32'(vecs[i].diff));
            chk("vec_bout", 32'(bo), 32'(vecs[i].bout));
         end
      end

      // operands changed right after accept (do_op turns 0xAAAA into 0x5555)
      do_op(0, 16'hAAAA, 16'h1111, 1'b0, 0, d, bo, lat);
      chk("late_change_diff", 32'(d), 32'h9999);
      chk("late_change_bout", 32'(bo), 32'd0);

      // backpressure with a competing request while busy
      in_valid[0] = 1'b1;
      a_in[0]     = 16'h0010;
      b_in[0]     = 16'h0020;
      bin_in[0]   = 1'b0;
      @(negedge clk);
      a_in[0] = 16'h0300;
      b_in[0] = 16'h0001;
      lat = 0;
      while (!out_valid[0] && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("bp_latency", 32'(lat), 32'd16);
      chk("bp_diff", 32'(diff_o[0]), 32'hFFF0);
      chk("bp_bout", 32'(bout_o[0]), 32'd1);
      for (int h = 0; h < 5; h++) begin
         @(negedge clk);
         chk("bp_valid", 32'(out_valid[0]), 32'd1);
         chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
         chk("bp_diff_hold", 32'(diff_o[0]), 32'hFFF0);
         chk("bp_bout_hold", 32'(bout_o[0]), 32'd1);
      end
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      @(negedge clk);
      out_ready[0] = 1'b0;
      chk("bp_release_valid", 32'(out_valid[0]), 32'd0);
      chk("bp_release_state", 32'(state_o[0]), 32'(IDLE));
      repeat (3) @(negedge clk);
      chk("bp_ignored_state", 32'(state_o[0]), 32'(IDLE));
      chk("idle_diff_kept", 32'(diff_o[0]), 32'hFFF0);
      out_ready[0] = 1'b1;
      @(negedge clk);
      out_ready[0] = 1'b0;
      chk("stray_out_ready", 32'(state_o[0]), 32'(IDLE));

      // reset in the middle of RUN
      in_valid[0] = 1'b1;
      a_in[0]     = 16'h1234;
      b_in[0]     = 16'h0001;
      bin_in[0]   = 1'b0;
      @(negedge clk);
      in_valid[0] = 1'b0;
      repeat (6) @(negedge clk);
      chk("pre_rst_state", 32'(state_o[0]), 32'(RUN));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid[0]), 32'd0);
      chk("mid_rst_diff", 32'(diff_o[0]), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_op(0, 16'd5, 16'd3, 1'b0, 0, d, bo, lat);
      chk("post_rst_diff", 32'(d), 32'd2);
      chk("post_rst_bout", 32'(bo), 32'd0);

      // random operations through a scoreboard, both digit sizes
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 1000; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rbi;
            logic [16:0] e;
            ra  = 16'($urandom_range(0, 65535));
            rb  = 16'($urandom_range(0, 65535));
            rbi = 1'($urandom_range(0, 1));
            exp_q.push_back({1'b0, ra} - {1'b0, rb} - 17'(rbi));
            do_op(s, ra, rb, rbi, $urandom_range(0, 2), d, bo, lat);
            e = exp_q.pop_front();
            chk("rand_latency", 32'(lat), 32'(n_of(s)));
            chk("rand_result", 32'({bo, d}), 32'(e));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
